fnd_scan_driver: RTL

FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

---
 rtl/fnd_scan_driver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fnd_scan_driver.sv
// Multiplexed 7-segment scan driver with shadow-loaded content, leading-zero blanking and blink.
// Define FND_BRIGHTNESS_EN to enable the 3-bit PWM brightness gate on the digit enables.
module fnd_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 100_000,
  parameter int BLINK_SLOTS = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [2:0]              brightness,
  output logic [NUM_DIGITS-1:0]   fnd_com,
  output logic [7:0]              fnd_data
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;

  logic [DW-1:0]           div_q, div_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q, blink_q;
  logic                    lz_q;
  logic [NUM_DIGITS-1:0]   com_q, com_d;
  logic [7:0]              data_q, data_d;
  logic                    tick;
  logic [3:0]              nib;
  logic                    zero_above;

  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

`ifdef FND_BRIGHTNESS_EN
  logic [2:0] pwm_q, pwm_d;
  logic [2:0] bright_q;
  assign pwm_d = pwm_q + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q    <= '0;
      bright_q <= '0;
    end else begin
      pwm_q <= pwm_d;
      if (load) bright_q <= brightness;
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  assign tick = (div_q == DW'(SCAN_DIV - 1));

  // Outputs are built from next-state counters so the registered outputs line up with the slot.
  always_comb begin
    div_d       = tick ? '0 : div_q + DW'(1);
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      if (blink_cnt_q == BW'(BLINK_SLOTS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    nib        = digits_q[{idx_d, 2'b00} +: 4];
    zero_above = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_d) && digits_q[4*i +: 4] != 4'h0) zero_above = 1'b0;
    end

    data_d    = seg7(nib);
    data_d[7] = ~dp_q[idx_d];
    if ((lz_q && idx_d != '0 && zero_above) || (phase_d && blink_q[idx_d])) data_d = 8'hFF;

    com_d = ~(NUM_DIGITS'(1) << idx_d);
    if (div_d == '0) com_d = '1;
`ifdef FND_BRIGHTNESS_EN
    if (pwm_d > bright_q) com_d = '1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q       <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      digits_q    <= '0;
      dp_q        <= '0;
      blink_q     <= '0;
      lz_q        <= 1'b0;
      com_q       <= '1;
      data_q      <= 8'hFF;
    end else begin
      div_q       <= div_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      com_q       <= com_d;
      data_q      <= data_d;
      if (load) begin
        digits_q <= digits;
        dp_q     <= dp_mask;
        blink_q  <= blink_mask;
        lz_q     <= lz_en;
      end
    end
  end

  assign fnd_com  = com_q;
  assign fnd_data = data_q;

endmodule
